mov_sprite_loader: RTL and testbench
====================================

Name: mov_sprite_loader

Overview:
- Write-side counterpart of the moving-sprite pattern memory.
- Accepts a byte stream over a valid/ready handshake: one command byte, then 64 packed pixel bytes.
- Unpacks each byte into four 2-bit pixels and writes them into the sprite RAM write port, one pixel per clock, at address {x, y}.
- Sits between the host/UART byte source and the per-sprite RAM write enables, so sprite patterns can be replaced at run time instead of only from mif files.

Parameters:
- NUM_SPRITES, 2, number of populated sprite RAMs; legal select values are 0..NUM_SPRITES-1 (maximum 64).
- CMD_TAG, 2'b10, required value of command byte bits [7:6].

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte source has data.
- in_data  in  8  byte from the source.
- in_ready  out  1  loader accepts in_data this cycle.
- wr_en  out  1  pixel write strobe.
- wr_sprite  out  6  target sprite select.
- wr_addr  out  8  {x[3:0], y[3:0]}; y is the low nibble and increments fastest.
- wr_data  out  2  pixel value.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse after the last pixel write (or after the checksum check, see Optional Feature).
- cmd_err  out  1  one-cycle pulse when a command byte is rejected.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_sprite=0, wr_addr=0, wr_data=0, busy=0, done=0, cmd_err=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-transfer aborts the transfer. Pixels already written stay in the RAM; there is no rollback.
- A byte transfers only on a clock edge with in_valid && in_ready. in_data is ignored otherwise.
- State IDLE:
  - in_ready=1.
  - On a transfer, check the byte. Valid means in_data[7:6]==CMD_TAG and in_data[5:0]<NUM_SPRITES.
  - Valid: latch wr_sprite=in_data[5:0], clear the pixel counter to 0, set busy=1, go to LOAD.
  - Invalid: pulse cmd_err next cycle, stay in IDLE.
- State LOAD:
  - in_ready=1.
  - On a transfer, latch the byte into the shift register and go to UNPACK.
  - With no transfer, wait indefinitely; there is no timeout.
- State UNPACK:
  - in_ready=0. Lasts 4 cycles with wr_en=1 in each.
  - Pixel k (k=0..3) is byte bits [2k+1:2k], LSB pair first.
  - wr_addr = pixel counter, which increments by 1 after each write.
  - After the 4th write:
    - If the counter has wrapped 255->0 (256 pixels written), go to DONE.
    - Otherwise go to LOAD.
- State DONE:
  - done=1 for one cycle, busy=0 at the next edge, return to IDLE.
  - in_ready=0 during DONE.
- Latency and throughput:
  - Byte accepted at edge N gives writes with wr_en high in cycles N+1..N+4.
  - Throughput is 1 byte per 5 cycles.
  - A full sprite takes a minimum of 1 + 64×5 + 1 cycles.
- Width rule: the 8-bit pixel counter wraps naturally at 256. The wrap, detected at the 256th write, is the end condition.
- wr_sprite is stable for the whole transfer. wr_addr and wr_data are only meaningful while wr_en=1.

Optional Feature:
- Macro: MOV_SPRITE_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the 64th payload byte is unpacked, the FSM enters state CHECK (in_ready=1) and accepts one trailer byte.
  - The trailer byte must equal the XOR of all 64 payload bytes.
  - Adds output csum_err (1 bit, reset 0). On mismatch, csum_err is set sticky until the next valid command is accepted. On match it stays 0.
  - Then DONE as normal.
- Without the macro: no CHECK state, no csum_err port, and UNPACK goes directly to DONE.

Decomposition:
- Shared package mov_sprite_pkg holds:
  - Constants: SPRITE_DIM=16, PIX_W=2, ADDR_W=8, SEL_W=6, PIX_PER_BYTE=4, BYTES_PER_SPRITE=64.
  - State enum: IDLE, LOAD, UNPACK, CHECK, DONE.
  - Helper for building {x, y} addresses.
- One natural sub-module: mov_sprite_unpacker. It owns the byte shift register, 2-bit pixel index and write strobe, and signals "last pixel of byte". The top level keeps the FSM, pixel counter and command decode.

Test Plan:
- Command 8'h80 then 64 bytes of 8'hE4 -> 256 writes to sprite 0; each byte gives wr_data 0,1,2,3 at wr_addr 0..255 ascending; done pulses once, cycle 322 after the command edge.
- Command 8'h81 with in_valid toggling 1-0-1 each cycle -> transfers only on valid&&ready; all 256 writes present with addresses in order; wr_sprite=1 throughout.
- Command 8'h05 (bad tag) and 8'h82 (select 2 ≥ NUM_SPRITES) -> cmd_err pulses, busy stays 0, no wr_en.
- Reset_n low after 10 payload bytes, then 8'h80 plus 64 bytes -> outputs at reset values immediately; the new transfer restarts at wr_addr 0.
- Byte 8'h1B at payload index 63 -> last writes are addr 8'hFC..8'hFF with data 3,2,1,0; counter wraps and the FSM enters DONE, not LOAD.
- With MOV_SPRITE_LOADER_CHECKSUM_EN: payload of 64×8'hE4 (XOR 0) with trailer 8'h00 -> csum_err=0; the same payload with trailer 8'h01 -> csum_err=1 until the next valid command.

Source files
------------

// File: rtl/mov_sprite_pkg.sv
// Shared constants, FSM state encoding and address helper for the moving-sprite loader.
package mov_sprite_pkg;
    localparam int SPRITE_DIM       = 16;
    localparam int PIX_W            = 2;
    localparam int ADDR_W           = 8;
    localparam int SEL_W            = 6;
    localparam int PIX_PER_BYTE     = 4;
    localparam int BYTES_PER_SPRITE = 64;
    localparam int COORD_W          = $clog2(SPRITE_DIM);

    // Address of the final pixel; its write wraps the pixel counter back to 0.
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(BYTES_PER_SPRITE * PIX_PER_BYTE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UNPACK,
        CHECK,
        DONE
    } state_t;

    // y is the low nibble so it advances fastest.
    function automatic logic [ADDR_W-1:0] sprite_addr(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction
endpackage

// File: rtl/mov_sprite_unpacker.sv
// Splits a loaded byte into four 2-bit pixels, LSB pair first; wr_en is high the 4 cycles after load.
// No backpressure: the caller must not load again until last has been seen.
module mov_sprite_unpacker
    import mov_sprite_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [7:0]       load_data,
    output logic             wr_en,
    output logic [PIX_W-1:0] wr_data,
    output logic             last
);
    logic [5:0] shift_reg;
    logic [1:0] pix_idx;

    assign last = wr_en && (pix_idx == 2'(PIX_PER_BYTE - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            pix_idx   <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
        end else if (load) begin
            // Pixel 0 goes straight to the output; the other three wait in the shifter.
            shift_reg <= load_data[7:2];
            wr_data   <= load_data[1:0];
            pix_idx   <= '0;
            wr_en     <= 1'b1;
        end else if (wr_en) begin
            if (last) begin
                wr_en <= 1'b0;
            end else begin
                wr_data   <= shift_reg[1:0];
                shift_reg <= {2'b00, shift_reg[5:2]};
                pix_idx   <= pix_idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/mov_sprite_loader.sv
// Byte-stream sprite pattern loader: command byte + 64 packed bytes -> 256 pixel writes; 1 byte per 5 cycles.
// in_ready drops while a byte unpacks; MOV_SPRITE_LOADER_CHECKSUM_EN adds an XOR trailer check and csum_err.
module mov_sprite_loader
    import mov_sprite_pkg::*;
#(
    parameter int         NUM_SPRITES = 2,
    parameter logic [1:0] CMD_TAG     = 2'b10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sprite,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
    output logic              csum_err,
`endif
    output logic              cmd_err
);
    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic              xfer;
    logic              cmd_ok;
    logic              unp_load;
    logic              unp_last;
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]        csum_acc;
`endif

    assign xfer     = in_valid && in_ready;
    assign cmd_ok   = (in_data[7:6] == CMD_TAG) && ({1'b0, in_data[5:0]} < 7'(NUM_SPRITES));
    assign unp_load = (state == LOAD) && xfer;
    assign wr_addr  = sprite_addr(pix_cnt[7:4], pix_cnt[3:0]);

    mov_sprite_unpacker u_unpacker (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (unp_load),
        .load_data (in_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .last      (unp_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            wr_sprite <= '0;
            pix_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
            csum_acc  <= '0;
            csum_err  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            if (wr_en) begin
                pix_cnt <= pix_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        if (cmd_ok) begin
                            wr_sprite <= in_data[5:0];
                            pix_cnt   <= '0;
                            busy      <= 1'b1;
                            state     <= LOAD;
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
                            csum_acc  <= '0;
                            csum_err  <= 1'b0;
`endif
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        state    <= UNPACK;
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc ^ in_data;
`endif
                    end
                end
                UNPACK: begin
                    if (unp_last) begin
                        // Writing the last address means the counter wraps to 0 on this edge.
                        if (pix_cnt == LAST_PIX) begin
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
                            state    <= CHECK;
                            in_ready <= 1'b1;
`else
                            state    <= DONE;
`endif
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                CHECK: begin
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
                    if (xfer) begin
                        csum_err <= (in_data != csum_acc);
                        in_ready <= 1'b0;
                        state    <= DONE;
                    end
`else
                    state    <= IDLE;
                    in_ready <= 1'b0;
`endif
                end
                DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mov_sprite_loader.sv
// Directed bench for mov_sprite_loader; pixel writes are logged and compared against the payload table.
module tb_mov_sprite_loader;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_sprite;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        busy;
    logic        done;
    logic        cmd_err;
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
    logic        csum_err;
`endif

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt = 0;
    int          cmd_cyc = 0;
    int          k;
    int          n;
    logic [15:0] wq[$];
    logic [7:0]  pay[64];

    mov_sprite_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_sprite (wr_sprite),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
        .csum_err  (csum_err),
`endif
        .cmd_err   (cmd_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        #1;
        if (wr_en) wq.push_back({wr_sprite, wr_addr, wr_data});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cmd_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_sprite(input logic [7:0] cmd);
        wq.delete();
        done_cnt = 0;
        send(cmd);
        cmd_cyc = cyc;
        for (int i = 0; i < 64; i++) send(pay[i]);
    endtask

    task automatic trailer_ok();
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 64; i++) x = x ^ pay[i];
        send(x);
`endif
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_cnt == 0 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_after"}, {31'd0, busy}, 0);
        check({tag, "_ready_after"}, {31'd0, in_ready}, 1);
    endtask

    task automatic verify(input string tag, input logic [5:0] spr);
        logic [7:0] b;
        logic [1:0] d;
        check({tag, "_nwrites"}, wq.size(), 256);
        for (int a = 0; a < 256 && a < wq.size(); a++) begin
            b = pay[a / 4];
            d = b[2 * (a % 4) +: 2];
            check({tag, "_write"}, {16'd0, wq[a]}, {16'd0, spr, 8'(a), d});
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_wr_sprite", {26'd0, wr_sprite}, 0);
        check("rst_wr_addr", {24'd0, wr_addr}, 0);
        check("rst_wr_data", {30'd0, wr_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_cmd_err", {31'd0, cmd_err}, 0);
`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
        check("rst_csum_err", {31'd0, csum_err}, 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 1);

        // Sprite 0, all bytes E4 -> pixels 0,1,2,3 repeating
        for (int i = 0; i < 64; i++) pay[i] = 8'hE4;
        wq.delete();
        done_cnt = 0;
        send(8'h80);
        cmd_cyc = cyc;
        check("cmd_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 64; i++) send(pay[i]);
        trailer_ok();
        wait_done("t1");
`ifndef MOV_SPRITE_LOADER_CHECKSUM_EN
        check("t1_done_cycle", done_cyc - cmd_cyc + 1, 322);
`endif
        verify("t1", 6'd0);

        // Sprite 1 with in_valid toggling every cycle and junk data while invalid
        for (int i = 0; i < 64; i++) pay[i] = 8'((i * 53) ^ 90);
        wq.delete();
        done_cnt = 0;
        send(8'h81);
        k = 0;
        n = 0;
        while (k < 64 && n < 2000) begin
            @(negedge clock);
            n++;
            in_valid = ~in_valid;
            in_data  = in_valid ? pay[k] : 8'hFF;
            if (in_valid && in_ready) k++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("t2_bytes_sent", k, 64);
        trailer_ok();
        wait_done("t2");
        verify("t2", 6'd1);

        // Rejected commands: bad tag, then select out of range
        wq.delete();
        err_cnt = 0;
        send(8'h05);
        check("bad_tag_cmd_err", {31'd0, cmd_err}, 1);
        repeat (2) @(posedge clock);
        #1;
        check("bad_tag_busy", {31'd0, busy}, 0);
        send(8'h82);
        check("bad_sel_cmd_err", {31'd0, cmd_err}, 1);
        repeat (2) @(posedge clock);
        #1;
        check("bad_sel_busy", {31'd0, busy}, 0);
        check("bad_err_pulses", err_cnt, 2);
        check("bad_no_writes", wq.size(), 0);
        check("bad_ready", {31'd0, in_ready}, 1);

        // Reset in the middle of a transfer, then a clean reload ending in byte 1B
        for (int i = 0; i < 64; i++) pay[i] = 8'(i * 29 + 7);
        pay[63] = 8'h1B;
        send(8'h81);
        for (int i = 0; i < 10; i++) send(pay[i]);
        reset_n = 1'b0;
        #1;
        check("abort_wr_en", {31'd0, wr_en}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_in_ready", {31'd0, in_ready}, 0);
        check("abort_wr_addr", {24'd0, wr_addr}, 0);
        check("abort_wr_sprite", {26'd0, wr_sprite}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_sprite(8'h80);
        trailer_ok();
        wait_done("t4");
        verify("t4", 6'd0);
        if (wq.size() == 256) begin
            check("last_w0", {16'd0, wq[252]}, {16'd0, 6'd0, 8'hFC, 2'd3});
            check("last_w1", {16'd0, wq[253]}, {16'd0, 6'd0, 8'hFD, 2'd2});
            check("last_w2", {16'd0, wq[254]}, {16'd0, 6'd0, 8'hFE, 2'd1});
            check("last_w3", {16'd0, wq[255]}, {16'd0, 6'd0, 8'hFF, 2'd0});
        end

`ifdef MOV_SPRITE_LOADER_CHECKSUM_EN
        for (int i = 0; i < 64; i++) pay[i] = 8'hE4;
        run_sprite(8'h80);
        send(8'h00);
        wait_done("cs_ok");
        check("csum_ok", {31'd0, csum_err}, 0);
        run_sprite(8'h80);
        send(8'h01);
        wait_done("cs_bad");
        check("csum_bad", {31'd0, csum_err}, 1);
        repeat (5) @(posedge clock);
        #1;
        check("csum_sticky", {31'd0, csum_err}, 1);
        send(8'h05);
        check("csum_sticky_badcmd", {31'd0, csum_err}, 1);
        send(8'h80);
        check("csum_cleared", {31'd0, csum_err}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
